// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: decodes size/address into lane enables and store data,
// runs a req/ack handshake with the data RAM with a bus timeout, and extends load results.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for an aligned mem_en; misaligned accesses flagged here
// ACCESS | ram_req held, pipeline stalled, waiting for ram_ack or timeout
// DONE   | one-cycle rdata_valid (and bus_err on timeout), back to IDLE
module mem_lsu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_en,
    input  logic             mem_we,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             ram_req,
    output logic             ram_we,
    output logic [3:0]       ram_be,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic             ram_ack,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             stall,
    output logic [WIDTH-1:0] rdata_out,
    output logic             rdata_valid,
    output logic             adel,
    output logic             ades,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             berr_q, berr_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;

    logic             misaligned;
    logic [3:0]       be_dec;
    logic [WIDTH-1:0] wdata_dec;
    logic [WIDTH-1:0] rd_shifted;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] load_ext;

    always_comb begin
        misaligned = ((mem_size == 2'b01) && addr[0]) ||
                     (mem_size[1] && (addr[1:0] != 2'b00));
        case (mem_size)
            2'b00: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {{(WIDTH-8){1'b0}}, wdata[7:0]} << {addr[1:0], 3'b000};
            end
            2'b01: begin
                be_dec    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {{(WIDTH-16){1'b0}}, wdata[15:0]} << {addr[1], 4'b0000};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = wdata;
            end
        endcase
    end

    // Extraction uses the size/offset latched at request time, not the live pipeline inputs.
    always_comb begin
        rd_shifted = ram_rdata >> {off_q, 3'b000};
        rd_half    = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(WIDTH-8){1'b0}}, rd_shifted[7:0]}
                                      : {{(WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_ext = uns_q ? {{(WIDTH-16){1'b0}}, rd_half}
                                      : {{(WIDTH-16){rd_half[15]}}, rd_half};
            default: load_ext = ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        valid_d = 1'b0;
        berr_d  = 1'b0;
        stall   = 1'b0;
        adel    = 1'b0;
        ades    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    if (misaligned) begin
                        adel = ~mem_we;
                        ades = mem_we;
                    end else begin
                        stall   = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_we;
                        be_d    = be_dec;
                        addr_d  = {addr[WIDTH-1:2], 2'b00};
                        wdata_d = wdata_dec;
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        off_d   = addr[1:0];
                        cnt_d   = '0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (ram_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    valid_d = 1'b1;
                    if (!we_q) rdata_d = load_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    rdata_d = '0;
                    valid_d = 1'b1;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            berr_q  <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            berr_q  <= berr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    assign ram_req     = req_q;
    assign ram_we      = we_q;
    assign ram_be      = be_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign rdata_out   = rdata_q;
    assign rdata_valid = valid_q;
    assign bus_err     = berr_q;

endmodule
